// File: rtl/conv_sched.sv
// Transmit scheduler for the PHY width converter: queues width-tagged words and
// replays each one for its 8-bit beat count, sequencing the converter mode when idle.
module conv_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        CLK,
    input  logic        ENB,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [31:0] up_data,
    input  logic [1:0]  up_width,
    input  logic        mode_req,
    output logic [31:0] conv_in,
    output logic [1:0]  conv_pclk,
    output logic        conv_modo,
    output logic        conv_valid,
    output logic [1:0]  beat,
    output logic        busy,
    output logic        err_width
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [33:0] r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    state_t      r_state;
    logic [31:0] r_conv_in;
    logic [1:0]  r_conv_pclk;
    logic        r_conv_modo;
    logic        r_conv_valid;
    logic [1:0]  r_beat;
    logic        r_err_width;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_last;
    logic        w_head_ill;
    logic [33:0] w_head;
    logic [1:0]  w_last_beat;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = up_valid && !w_full;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_head_ill = (w_head[33:32] == 2'b11);

    always_comb begin
        w_last_beat = 2'd0;
        case (r_conv_pclk)
            2'b00:   w_last_beat = 2'd3;
            2'b01:   w_last_beat = 2'd1;
            default: w_last_beat = 2'd0;
        endcase
    end

    assign w_last = (r_state == S_SEND) && (r_beat == w_last_beat);
    // The head is consumed whenever a new word could start: idle, or the final beat.
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || w_last);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {up_width, up_data};
        end
    end

    always_ff @(posedge CLK or negedge ENB) begin
        if (!ENB) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge ENB) begin
        if (!ENB) begin
            r_state      <= S_IDLE;
            r_conv_in    <= 32'd0;
            r_conv_pclk  <= 2'b00;
            r_conv_modo  <= 1'b0;
            r_conv_valid <= 1'b0;
            r_beat       <= 2'd0;
            r_err_width  <= 1'b0;
        end else begin
            r_err_width <= 1'b0;
            if ((r_state == S_IDLE) && w_empty) begin
                r_conv_modo <= mode_req;
            end else if ((r_state == S_SEND) && !w_last) begin
                r_beat <= r_beat + 2'd1;
            end else if (w_empty || w_head_ill) begin
                // Last beat with nothing usable next: drop back to idle, flag a bad width.
                r_state      <= S_IDLE;
                r_conv_valid <= 1'b0;
                r_beat       <= 2'd0;
                r_err_width  <= !w_empty;
            end else begin
                r_state      <= S_SEND;
                r_conv_in    <= w_head[31:0];
                r_conv_pclk  <= w_head[33:32];
                r_conv_valid <= 1'b1;
                r_beat       <= 2'd0;
            end
        end
    end

    assign up_ready   = !w_full;
    assign busy       = !w_empty || (r_state == S_SEND);
    assign conv_in    = r_conv_in;
    assign conv_pclk  = r_conv_pclk;
    assign conv_modo  = r_conv_modo;
    assign conv_valid = r_conv_valid;
    assign beat       = r_beat;
    assign err_width  = r_err_width;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: reset, single and back-to-back words, backpressure,
// illegal width drop, mode sequencing and mid-word reset.
module tb_conv_sched;

    logic        clk;
    logic        enb;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_data;
    logic [1:0]  up_width;
    logic        mode_req;
    logic [31:0] conv_in;
    logic [1:0]  conv_pclk;
    logic        conv_modo;
    logic        conv_valid;
    logic [1:0]  beat;
    logic        busy;
    logic        err_width;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [35:0] beats_q [$];

    conv_sched #(.DEPTH(4), .AW(2)) dut (
        .CLK        (clk),
        .ENB        (enb),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_width   (up_width),
        .mode_req   (mode_req),
        .conv_in    (conv_in),
        .conv_pclk  (conv_pclk),
        .conv_modo  (conv_modo),
        .conv_valid (conv_valid),
        .beat       (beat),
        .busy       (busy),
        .err_width  (err_width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every consumed beat as {data, width, beat index}.
    always @(negedge clk) begin
        if (conv_valid) beats_q.push_back({conv_in, conv_pclk, beat});
        if (err_width) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_up_ready"},   64'(up_ready),   64'd1);
        chk({tag, "_conv_in"},    64'(conv_in),    64'd0);
        chk({tag, "_conv_pclk"},  64'(conv_pclk),  64'd0);
        chk({tag, "_conv_modo"},  64'(conv_modo),  64'd0);
        chk({tag, "_conv_valid"}, 64'(conv_valid), 64'd0);
        chk({tag, "_beat"},       64'(beat),       64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_err_width"},  64'(err_width),  64'd0);
    endtask

    task automatic beat_chk(input string tag, input logic [31:0] d, input logic [1:0] w,
                            input logic [1:0] b);
        chk({tag, "_valid"}, 64'(conv_valid), 64'd1);
        chk({tag, "_data"},  64'(conv_in),    64'(d));
        chk({tag, "_pclk"},  64'(conv_pclk),  64'(w));
        chk({tag, "_beat"},  64'(beat),       64'(b));
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] w);
        up_valid = 1'b1;
        up_data  = d;
        up_width = w;
    endtask

    initial begin
        logic [31:0] t2_data [7];
        logic [1:0]  t2_pclk [7];
        logic [1:0]  t2_beat [7];
        logic [31:0] bp_data [5];
        int          n;
        int          err_base;

        t2_data = '{32'h000030EA, 32'h000030EA, 32'h000000AE, 32'h0F00FF55,
                    32'h0F00FF55, 32'h0F00FF55, 32'h0F00FF55};
        t2_pclk = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        t2_beat = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 5; k++) bp_data[k] = 32'hA0000000 + 32'(k);

        enb      = 1'b0;
        up_valid = 1'b0;
        up_data  = 32'd0;
        up_width = 2'b00;
        mode_req = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        enb = 1'b1;
        tick();

        // Single 32-bit word: 2-cycle latency, then 4 beats.
        drive(32'h0F00FF55, 2'b00);
        tick();
        up_valid = 1'b0;
        chk("t1_lat_valid", 64'(conv_valid), 64'd0);
        chk("t1_lat_busy",  64'(busy),       64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            beat_chk($sformatf("t1_b%0d", k), 32'h0F00FF55, 2'b00, 2'(k));
        end
        tick();
        chk("t1_end_valid", 64'(conv_valid), 64'd0);
        chk("t1_end_busy",  64'(busy),       64'd0);

        // Three words back to back: 7 beats with no gap.
        drive(32'h000030EA, 2'b01);
        tick();
        drive(32'h000000AE, 2'b10);
        tick();
        beat_chk("t2_b0", t2_data[0], t2_pclk[0], t2_beat[0]);
        drive(32'h0F00FF55, 2'b00);
        tick();
        up_valid = 1'b0;
        beat_chk("t2_b1", t2_data[1], t2_pclk[1], t2_beat[1]);
        for (int k = 2; k < 7; k++) begin
            tick();
            beat_chk($sformatf("t2_b%0d", k), t2_data[k], t2_pclk[k], t2_beat[k]);
        end
        tick();
        chk("t2_end_valid", 64'(conv_valid), 64'd0);
        chk("t2_end_busy",  64'(busy),       64'd0);

        // Backpressure: five pushes on five edges fill the 4-entry FIFO.
        beats_q.delete();
        for (int k = 0; k < 5; k++) begin
            drive(bp_data[k], 2'b00);
            chk($sformatf("t3_ready%0d", k), 64'(up_ready), 64'd1);
            tick();
        end
        up_valid = 1'b0;
        chk("t3_full_ready", 64'(up_ready), 64'd0);
        chk("t3_full_busy",  64'(busy),     64'd1);
        tick();
        chk("t3_freed_ready", 64'(up_ready), 64'd1);
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("t3_drain_busy", 64'(busy), 64'd0);
        chk("t3_beat_count", 64'(beats_q.size()), 64'd20);
        if (beats_q.size() >= 20) begin
            for (int k = 0; k < 20; k++) begin
                chk($sformatf("t3_q%0d", k), 64'(beats_q[k]),
                    64'({bp_data[k / 4], 2'b00, 2'(k % 4)}));
            end
        end

        // Illegal width between two legal words.
        beats_q.delete();
        err_base = err_cnt;
        drive(32'h00000011, 2'b10);
        tick();
        drive(32'hDEADBEEF, 2'b11);
        tick();
        beat_chk("t4_a", 32'h00000011, 2'b10, 2'd0);
        chk("t4_a_err", 64'(err_width), 64'd0);
        drive(32'h00000022, 2'b10);
        tick();
        up_valid = 1'b0;
        chk("t4_gap_valid", 64'(conv_valid), 64'd0);
        chk("t4_gap_err",   64'(err_width),  64'd1);
        chk("t4_gap_data",  64'(conv_in),    64'h00000011);
        tick();
        beat_chk("t4_b", 32'h00000022, 2'b10, 2'd0);
        chk("t4_b_err", 64'(err_width), 64'd0);
        tick();
        chk("t4_end_valid", 64'(conv_valid), 64'd0);
        chk("t4_err_pulses", 64'(err_cnt - err_base), 64'd1);
        chk("t4_q_size", 64'(beats_q.size()), 64'd2);
        if (beats_q.size() == 2) begin
            chk("t4_q0", 64'(beats_q[0][35:4]), 64'h00000011);
            chk("t4_q1", 64'(beats_q[1][35:4]), 64'h00000022);
        end

        // Mode change requested mid-send lands only once idle and empty.
        drive(32'h12345678, 2'b00);
        tick();
        up_valid = 1'b0;
        tick();
        mode_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t5_modo_hold%0d", k), 64'(conv_modo), 64'd0);
        end
        chk("t5_idle_valid", 64'(conv_valid), 64'd0);
        tick();
        chk("t5_modo_new", 64'(conv_modo), 64'd1);

        // Reset at beat 2 with two words queued.
        drive(32'h0000AAAA, 2'b00);
        tick();
        drive(32'h0000BBBB, 2'b00);
        tick();
        drive(32'h0000CCCC, 2'b00);
        tick();
        up_valid = 1'b0;
        tick();
        beat_chk("t6_pre", 32'h0000AAAA, 2'b00, 2'd2);
        enb = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        @(posedge clk);
        #1;
        enb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_quiet_valid%0d", k), 64'(conv_valid), 64'd0);
            chk($sformatf("t6_quiet_busy%0d", k),  64'(busy),       64'd0);
        end
        drive(32'h00005A5A, 2'b01);
        tick();
        up_valid = 1'b0;
        tick();
        beat_chk("t6_new_b0", 32'h00005A5A, 2'b01, 2'd0);
        tick();
        beat_chk("t6_new_b1", 32'h00005A5A, 2'b01, 2'd1);
        tick();
        chk("t6_end_valid", 64'(conv_valid), 64'd0);
        chk("t6_end_busy",  64'(busy),       64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
